// File: rtl/screensaver_pkg.sv
// Shared definitions for the bouncing-box screensaver.
//   - Screen and box geometry, also used by image and top.
//   - bounce_state_t: the per-frame update sequencer states of bounce_ctrl.
package screensaver_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BOX_WIDTH     = 100;
  localparam int BOX_HEIGHT    = 100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } bounce_state_t;

endpackage

// File: rtl/axis_bounce.sv
// One-axis position stepper with true edge reflection (purely combinational).
// Ports:
//   pos      : current working position (W bits, one wider than the screen coordinate)
//   dir      : current direction, 0 = increasing, 1 = decreasing
//   pos_next : position after one step
//   dir_next : direction after one step
//   hit      : step reflected off 0 or LIMIT
// Landing exactly on 0 or LIMIT is not a reflection; that happens on the next step.
module axis_bounce #(
  parameter int LIMIT = 540,
  parameter int SPEED = 2,
  parameter int W     = 11
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  output logic [W-1:0] pos_next,
  output logic         dir_next,
  output logic         hit
);

  localparam logic [W-1:0] LIM  = W'(LIMIT);
  localparam logic [W-1:0] LIM2 = W'(2 * LIMIT);
  localparam logic [W-1:0] SPD  = W'(SPEED);

  logic [W-1:0] t;

  always_comb begin
    t        = pos + SPD;
    pos_next = pos;
    dir_next = dir;
    hit      = 1'b0;
    if (!dir) begin
      // Overshoot past LIMIT folds back by the same distance.
      if (t > LIM) begin
        pos_next = LIM2 - t;
        dir_next = 1'b1;
        hit      = 1'b1;
      end else begin
        pos_next = t;
      end
    end else begin
      if (pos < SPD) begin
        pos_next = SPD - pos;
        dir_next = 1'b0;
        hit      = 1'b1;
      end else begin
        pos_next = pos - SPD;
      end
    end
  end

endmodule

// File: rtl/bounce_ctrl.sv
// Per-frame motion controller for the bouncing box. Each time the frame
// counter changes, the box is stepped in X then Y and the results are
// committed together to the shadowed outputs.
//
// state  | meaning
// IDLE   | waiting for frame != frame_prev
// STEP_X | advance working x / dir_x, latch X hit
// STEP_Y | advance working y / dir_y, latch Y hit
// COMMIT | publish box_x/box_y/color, pulse hit_v/hit_h/update_done
//
// Ports:
//   clk, rst     : pixel clock, synchronous active-high reset
//   frame        : frame counter from video_timer
//   box_x, box_y : box origin (registered, change only on commit)
//   color        : {b,g,r} box colour, never 0
//   hit_v, hit_h : one-cycle reflection pulses (left/right, top/bottom)
//   update_done  : one-cycle pulse when new outputs are valid
module bounce_ctrl #(
  parameter int SCREEN_WIDTH  = screensaver_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = screensaver_pkg::SCREEN_HEIGHT,
  parameter int BOX_WIDTH     = screensaver_pkg::BOX_WIDTH,
  parameter int BOX_HEIGHT    = screensaver_pkg::BOX_HEIGHT,
  parameter int INIT_X        = 50,
  parameter int INIT_Y        = 50,
  parameter int SPEED_X       = 2,
  parameter int SPEED_Y       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      frame,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  box_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] box_y,
  output logic [2:0]                       color,
  output logic                             hit_v,
  output logic                             hit_h,
  output logic                             update_done
);

  import screensaver_pkg::*;

  localparam int XW   = $clog2(SCREEN_WIDTH);
  localparam int YW   = $clog2(SCREEN_HEIGHT);
  localparam int WX   = XW + 1;
  localparam int WY   = YW + 1;
  localparam int XMAX = SCREEN_WIDTH - BOX_WIDTH;
  localparam int YMAX = SCREEN_HEIGHT - BOX_HEIGHT;

  bounce_state_t state_q, state_d;
  logic [31:0]   frame_prev_q, frame_prev_d;
  logic [WX-1:0] x_q, x_d, x_step;
  logic [WY-1:0] y_q, y_d, y_step;
  logic          dir_x_q, dir_x_d, dir_x_step;
  logic          dir_y_q, dir_y_d, dir_y_step;
  logic          hx_q, hx_d, hx_step;
  logic          hy_q, hy_d, hy_step;
  logic [XW-1:0] box_x_q, box_x_d;
  logic [YW-1:0] box_y_q, box_y_d;
  logic [2:0]    color_q, color_d;
  logic          hit_v_q, hit_v_d;
  logic          hit_h_q, hit_h_d;
  logic          update_done_q, update_done_d;

  axis_bounce #(.LIMIT(XMAX), .SPEED(SPEED_X), .W(WX)) u_axis_x (
    .pos      (x_q),
    .dir      (dir_x_q),
    .pos_next (x_step),
    .dir_next (dir_x_step),
    .hit      (hx_step)
  );

  axis_bounce #(.LIMIT(YMAX), .SPEED(SPEED_Y), .W(WY)) u_axis_y (
    .pos      (y_q),
    .dir      (dir_y_q),
    .pos_next (y_step),
    .dir_next (dir_y_step),
    .hit      (hy_step)
  );

  always_comb begin
    state_d       = state_q;
    frame_prev_d  = frame_prev_q;
    x_d           = x_q;
    y_d           = y_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    hx_d          = hx_q;
    hy_d          = hy_q;
    box_x_d       = box_x_q;
    box_y_d       = box_y_q;
    color_d       = color_q;
    hit_v_d       = 1'b0;
    hit_h_d       = 1'b0;
    update_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A frame change during an update is picked up here on return.
        if (frame != frame_prev_q) begin
          frame_prev_d = frame;
          state_d      = STEP_X;
        end
      end
      STEP_X: begin
        x_d     = x_step;
        dir_x_d = dir_x_step;
        hx_d    = hx_step;
        state_d = STEP_Y;
      end
      STEP_Y: begin
        y_d     = y_step;
        dir_y_d = dir_y_step;
        hy_d    = hy_step;
        state_d = COMMIT;
      end
      COMMIT: begin
        box_x_d       = x_q[XW-1:0];
        box_y_d       = y_q[YW-1:0];
        hit_v_d       = hx_q;
        hit_h_d       = hy_q;
        update_done_d = 1'b1;
        hx_d          = 1'b0;
        hy_d          = 1'b0;
        // Corner hits advance the colour once; 7 wraps to 1, skipping black.
        if (hx_q || hy_q) begin
          color_d = (color_q == 3'd7) ? 3'd1 : color_q + 3'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      frame_prev_q  <= 32'hFFFF_FFFF;
      x_q           <= WX'(INIT_X);
      y_q           <= WY'(INIT_Y);
      dir_x_q       <= 1'b0;
      dir_y_q       <= 1'b0;
      hx_q          <= 1'b0;
      hy_q          <= 1'b0;
      box_x_q       <= XW'(INIT_X);
      box_y_q       <= YW'(INIT_Y);
      color_q       <= 3'b111;
      hit_v_q       <= 1'b0;
      hit_h_q       <= 1'b0;
      update_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_prev_q  <= frame_prev_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      hx_q          <= hx_d;
      hy_q          <= hy_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      color_q       <= color_d;
      hit_v_q       <= hit_v_d;
      hit_h_q       <= hit_h_d;
      update_done_q <= update_done_d;
    end
  end

  assign box_x       = box_x_q;
  assign box_y       = box_y_q;
  assign color       = color_q;
  assign hit_v       = hit_v_q;
  assign hit_h       = hit_h_q;
  assign update_done = update_done_q;

endmodule
